ov7670_stream_bridge: RTL
=========================

Name: ov7670_stream_bridge

Overview:
- Parametrised camera-to-display pixel bridge.
- Takes OV7670 byte traffic already synchronised into the system clock domain and assembles RGB565 pixels.
- Applies a per-frame crop window and power-of-two decimation, then buffers pixels in a FIFO.
- Presents a valid/ready stream with start-of-frame and end-of-line flags to the ILI9341 driver, replacing the direct href/vsync coupling.

Parameters:
- BYTE_W, 8, camera data bus width.
- PIXEL_W, 16, assembled pixel width (2*BYTE_W).
- FIFO_DEPTH, 64, pixel FIFO entries (power of two, >=4).
- COL_W, 10, column counter / window x width.
- ROW_W, 9, row counter / window y width.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cam_vsync  in  1  camera vsync, synchronised, high = blanking.
- cam_href  in  1  camera href, synchronised, high = active line.
- cam_byte_valid  in  1  one-cycle strobe per camera byte.
- cam_data  in  BYTE_W  camera byte, valid with cam_byte_valid.
- win_x  in  COL_W  crop start column.
- win_y  in  ROW_W  crop start row.
- win_w  in  COL_W  crop width in source pixels.
- win_h  in  ROW_W  crop height in source rows.
- dec  in  2  decimation: 0=1:1, 1=1/2, 2=1/4, 3=1/8.
- ovf_clr  in  1  clears the sticky overflow flag.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accept.
- m_data  out  PIXEL_W  RGB565 pixel.
- m_sof  out  1  first pixel of frame.
- m_eol  out  1  last pixel of line.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high):
  - FSM to IDLE; FIFO flushed.
  - m_valid=0, m_data=0, m_sof=0, m_eol=0, overflow=0, fifo_level=0.
  - Counters and byte phase cleared.
- FSM states:
  - IDLE: go to SYNC when cam_vsync=1.
  - SYNC: on cam_vsync falling, shadow win_*/dec into registers, clear row counter, arm sof, go to FRAME.
  - FRAME: capture. On cam_vsync rising, go to SYNC.
  - Reset mid-frame never yields a partial frame; a full vsync pulse is required first.
- Byte assembly (FRAME only, cam_href=1):
  - First strobe of a pair is the high byte, second is the low byte.
  - Byte phase clears on cam_href rising and on any cam_vsync edge.
  - An odd trailing byte at cam_href falling is discarded.
- Counters:
  - col increments per assembled pixel and clears on cam_href falling.
  - row increments on cam_href falling when col>0.
  - Both saturate at all-ones; no wrap.
- Window/decimation pass condition:
  - win_x <= col < win_x+win_w, win_y <= row < win_y+win_h.
  - (col-win_x) mod 2^dec = 0 and (row-win_y) mod 2^dec = 0.
  - Sums are computed at COL_W+1 / ROW_W+1 bits, so a window extending past the counter range clips without wrap.
  - win_w must be a multiple of 2^dec.
- Flags:
  - eol is set on the passed pixel with col = win_x+win_w-2^dec.
  - sof is set on the first passed pixel after arming, then disarmed.
- Latency:
  - Low byte strobe at cycle N -> FIFO write at N+1 -> m_valid at N+2 when the FIFO was empty (first-word fall-through, registered outputs).
- Handshake:
  - m_data/m_sof/m_eol are held stable while m_valid=1 and m_ready=0.
  - Pop occurs on m_valid&m_ready.
- Full/empty boundary cases:
  - Write when full with a simultaneous pop: accepted.
  - Write when full without a pop: pixel dropped, overflow set.
  - ovf_clr and a new overflow in the same cycle: overflow stays 1.
  - m_valid=0 when empty.

Optional Feature:
- Macro OV7670_STREAM_STATS_EN.
- When defined, the block adds outputs:
  - frame_count (16b): increments on each FRAME->SYNC transition, wraps.
  - drop_count (16b): increments per dropped pixel or discarded odd byte, saturates; cleared by reset and ovf_clr.
- When undefined, these ports and their counters are absent. All other behaviour is identical.

Decomposition:
- Package ov7670_stream_pkg:
  - pixel_t; fifo_entry_t struct {sof, eol, pixel_t}.
  - state_t enum {IDLE, SYNC, FRAME}.
  - dec_t; RGB565 field constants.
- Sub-module stream_sync_fifo: parametrised width/depth synchronous FIFO with level output, first-word fall-through.

Test Plan:
- Reset, one vsync pulse, then 4 lines x 8 pixels (bytes 0xA0,0x01..); window 0,0,8,4, dec=0 -> 32 pixels out, first m_data=0xA001 with m_sof=1; m_eol on every 8th pixel; overflow=0.
- Same frame with win_x=2, win_y=1, win_w=4, win_h=2, dec=1 -> exactly 2 pixels: (col2,row1) with sof=1, eol=0; (col4,row1) with sof=0, eol=1.
- m_ready=0 for a 100-pixel full-window frame with FIFO_DEPTH=64 -> fifo_level=64, overflow=1; release m_ready -> first 64 pixels delivered in order; ovf_clr -> overflow=0.
- Reset asserted mid-line, then href/data continue without a vsync -> m_valid stays 0; after the next vsync pulse, capture resumes with m_sof=1.
- 3 bytes within one href -> 1 pixel out, odd byte dropped; with OV7670_STREAM_STATS_EN, drop_count=1 and frame_count=1 after the next vsync rising edge.

Source files
------------

// File: rtl/ov7670_stream_pkg.sv
// rtl/ov7670_stream_pkg.sv - shared types and constants for the OV7670 stream bridge
package ov7670_stream_pkg;

    localparam int PIX_BITS = 16;

    typedef logic [PIX_BITS-1:0] pixel_t;

    typedef struct packed {
        logic   sof;
        logic   eol;
        pixel_t pixel;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        FRAME = 2'd2
    } state_t;

    // Decimation exponent: pass every 2^dec-th column and row
    typedef logic [1:0] dec_t;

    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_R_W   = 5;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_G_W   = 6;
    localparam int RGB565_B_LSB = 0;
    localparam int RGB565_B_W   = 5;

endpackage

// File: rtl/stream_sync_fifo.sv
// rtl/stream_sync_fifo.sv - synchronous first-word fall-through FIFO with level output
module stream_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [AW:0]      level_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             full;
    logic             pop;
    logic             push;

    assign full = (level_q == (AW+1)'(DEPTH));
    assign pop  = rd_en_i && (level_q != '0);
    // A pop in the same cycle frees the slot the write lands in
    assign push = wr_en_i && (!full || pop);

    assign drop_o     = wr_en_i && full && !pop;
    assign rd_valid_o = (level_q != '0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o    = level_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + (AW+1)'(1);
            end else if (pop && !push) begin
                level_q <= level_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ov7670_stream_bridge.sv
// rtl/ov7670_stream_bridge.sv - OV7670 byte stream to cropped/decimated RGB565 valid/ready stream
// Optional frame/drop statistics ports under OV7670_STREAM_STATS_EN.
module ov7670_stream_bridge
    import ov7670_stream_pkg::*;
#(
    parameter int BYTE_W     = 8,
    parameter int PIXEL_W    = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cam_vsync,
    input  logic               cam_href,
    input  logic               cam_byte_valid,
    input  logic [BYTE_W-1:0]  cam_data,
    input  logic [COL_W-1:0]   win_x,
    input  logic [ROW_W-1:0]   win_y,
    input  logic [COL_W-1:0]   win_w,
    input  logic [ROW_W-1:0]   win_h,
    input  logic [1:0]         dec,
    input  logic               ovf_clr,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [PIXEL_W-1:0] m_data,
    output logic               m_sof,
    output logic               m_eol,
    output logic               overflow,
    output logic [LVL_W-1:0]   fifo_level
`ifdef OV7670_STREAM_STATS_EN
    ,
    output logic [15:0]        frame_count,
    output logic [15:0]        drop_count
`endif
);

    state_t             state_q;
    logic               vsync_q;
    logic               href_q;
    logic               phase_q;
    logic [BYTE_W-1:0]  hi_q;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   wx_q;
    logic [COL_W-1:0]   ww_q;
    logic [ROW_W-1:0]   wy_q;
    logic [ROW_W-1:0]   wh_q;
    dec_t               dec_q;
    logic               sof_arm_q;
    logic               wr_en_q;
    logic [PIXEL_W+1:0] wr_entry_q;
    logic               overflow_q;

    logic vs_rise, vs_fall, vs_edge, href_rise, href_fall;
    logic capture, phase_eff, pix_fire, odd_drop, fifo_drop, pop;

    assign vs_rise   = cam_vsync && !vsync_q;
    assign vs_fall   = !cam_vsync && vsync_q;
    assign vs_edge   = vs_rise || vs_fall;
    assign href_rise = cam_href && !href_q;
    assign href_fall = !cam_href && href_q;

    assign capture   = (state_q == FRAME) && cam_href && cam_byte_valid;
    assign phase_eff = phase_q && !href_rise && !vs_edge;
    assign pix_fire  = capture && phase_eff;
    assign odd_drop  = (state_q == FRAME) && href_fall && phase_q;

    // Window arithmetic is one bit wider so a window past the counter range clips
    logic [COL_W:0] col_x, x_lo, x_hi, step_x, off_x;
    logic [ROW_W:0] row_y, y_lo, y_hi, step_y, off_y;
    logic           x_ok, y_ok, pass, eol_hit;

    assign col_x  = {1'b0, col_q};
    assign x_lo   = {1'b0, wx_q};
    assign x_hi   = x_lo + {1'b0, ww_q};
    assign step_x = (COL_W+1)'(1) << dec_q;
    assign off_x  = col_x - x_lo;
    assign x_ok   = (col_x >= x_lo) && (col_x < x_hi)
                 && ((off_x & (step_x - (COL_W+1)'(1))) == '0);

    assign row_y  = {1'b0, row_q};
    assign y_lo   = {1'b0, wy_q};
    assign y_hi   = y_lo + {1'b0, wh_q};
    assign step_y = (ROW_W+1)'(1) << dec_q;
    assign off_y  = row_y - y_lo;
    assign y_ok   = (row_y >= y_lo) && (row_y < y_hi)
                 && ((off_y & (step_y - (ROW_W+1)'(1))) == '0);

    assign pass    = x_ok && y_ok;
    assign eol_hit = (col_x == (x_hi - step_x));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            wx_q       <= '0;
            ww_q       <= '0;
            wy_q       <= '0;
            wh_q       <= '0;
            dec_q      <= '0;
            sof_arm_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_entry_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            vsync_q <= cam_vsync;
            href_q  <= cam_href;
            wr_en_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cam_vsync) begin
                        state_q <= SYNC;
                    end
                end
                SYNC: begin
                    if (vs_fall) begin
                        wx_q      <= win_x;
                        ww_q      <= win_w;
                        wy_q      <= win_y;
                        wh_q      <= win_h;
                        dec_q     <= dec;
                        col_q     <= '0;
                        row_q     <= '0;
                        sof_arm_q <= 1'b1;
                        state_q   <= FRAME;
                    end
                end
                FRAME: begin
                    if (vs_rise) begin
                        state_q <= SYNC;
                    end
                    if (href_fall) begin
                        col_q <= '0;
                        if ((col_q != '0) && (row_q != '1)) begin
                            row_q <= row_q + ROW_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (vs_edge || href_rise || href_fall) begin
                phase_q <= 1'b0;
            end
            if (capture) begin
                if (phase_eff) begin
                    phase_q <= 1'b0;
                end else begin
                    hi_q    <= cam_data;
                    phase_q <= 1'b1;
                end
            end

            if (pix_fire) begin
                if (col_q != '1) begin
                    col_q <= col_q + COL_W'(1);
                end
                if (pass) begin
                    wr_en_q    <= 1'b1;
                    wr_entry_q <= {sof_arm_q, eol_hit, hi_q, cam_data};
                    sof_arm_q  <= 1'b0;
                end
            end

            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    logic [PIXEL_W+1:0] rd_entry;

    assign pop = m_valid && m_ready;

    stream_sync_fifo #(
        .WIDTH (PIXEL_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_en_q),
        .wr_data_i  (wr_entry_q),
        .rd_en_i    (pop),
        .rd_valid_o (m_valid),
        .rd_data_o  (rd_entry),
        .level_o    (fifo_level),
        .drop_o     (fifo_drop)
    );

    assign {m_sof, m_eol, m_data} = rd_entry;
    assign overflow               = overflow_q;

`ifdef OV7670_STREAM_STATS_EN
    logic [15:0] frame_count_q;
    logic [15:0] drop_count_q;
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, (ovf_clr ? 16'd0 : drop_count_q)} + 17'(fifo_drop) + 17'(odd_drop);

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            if ((state_q == FRAME) && vs_rise) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            drop_count_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
`endif

endmodule
